// File: rtl/read_control.sv
// Reads packages back from the even/odd interleaved memories and streams them as 16-bit words.
// Optional build macro READ_CONTROL_CHECKSUM_EN appends a modulo-2^16 sum word that carries eop.
`timescale 1ns/1ps
module read_control #(
  parameter int PACKAGE_LENGTH = 1036,
  parameter int MEMORY_DEPTH   = 24576,
  parameter int READ_LATENCY   = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        live_rising,
  input  logic        wr_pkg_done,
  output logic [14:0] even_rdaddr,
  input  logic [15:0] even_q,
  output logic [14:0] odd_rdaddr,
  input  logic [15:0] odd_q,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy,
  output logic [5:0]  pkg_pending,
  output logic        overflow
);
  localparam int HALF        = PACKAGE_LENGTH / 2;
  localparam int MAX_PENDING = MEMORY_DEPTH / HALF;
`ifdef READ_CONTROL_CHECKSUM_EN
  localparam int ISSUES = PACKAGE_LENGTH + 1;
`else
  localparam int ISSUES = PACKAGE_LENGTH;
`endif
  localparam int KW  = $clog2(ISSUES + 1);
  localparam int FW  = $clog2(FIFO_DEPTH);
  localparam int TOP = READ_LATENCY - 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [14:0]   base_reg, base_next;
  logic [KW-1:0] k_reg, k_next;
  logic [5:0]    pending_reg, pending_next;
  logic          overflow_reg, overflow_next;
  logic          clear, issue, start, credit_ok, chk_issue;
  logic [31:0]   inflight;
  logic [14:0]   rd_addr, base_adv;

  logic [READ_LATENCY-1:0] pipe_valid_reg, pipe_odd_reg, pipe_sop_reg, pipe_eop_reg;

  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wptr_reg, rptr_reg;
  logic [FW:0]   count_reg;
  logic [17:0]   head;
  logic [15:0]   ret_word, push_data;
  logic          push, pop;

  function automatic logic [14:0] wrap_add(input logic [14:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = {1'b0, a} + b;
    return (s >= 16'(MEMORY_DEPTH)) ? 15'(s - 16'(MEMORY_DEPTH)) : s[14:0];
  endfunction

  assign clear       = reset || live_rising;
  assign rd_addr     = wrap_add(base_reg, 16'(k_reg >> 1));
  assign base_adv    = wrap_add(base_reg, 16'(HALF));
  assign even_rdaddr = rd_addr;
  assign odd_rdaddr  = rd_addr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 32'(pipe_valid_reg[i]);
  end

  // Credit covers both buffered words and reads still in the RAM pipeline.
  assign credit_ok = (32'(count_reg) + inflight) < 32'(FIFO_DEPTH);

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    issue      = 1'b0;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          start      = 1'b1;
          k_next     = '0;
          state_next = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (k_reg == KW'(ISSUES - 1)) begin
            k_next     = '0;
            base_next  = base_adv;
            state_next = DRAIN;
          end else begin
            k_next = k_reg + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    if (wr_pkg_done && pending_reg == 6'(MAX_PENDING)) overflow_next = 1'b1;
    if (wr_pkg_done && !start && pending_reg != 6'(MAX_PENDING))
      pending_next = pending_reg + 6'd1;
    else if (start && !wr_pkg_done)
      pending_next = pending_reg - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      k_reg        <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      k_reg        <= k_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  // Return pipeline tracks each read until its data appears on even_q/odd_q.
  always_ff @(posedge clk) begin
    if (clear) pipe_valid_reg <= '0;
    else begin
      pipe_valid_reg[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid_reg[i] <= pipe_valid_reg[i-1];
    end
    pipe_odd_reg[0] <= k_reg[0];
    pipe_sop_reg[0] <= (k_reg == '0);
    pipe_eop_reg[0] <= (k_reg == KW'(ISSUES - 1));
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_odd_reg[i] <= pipe_odd_reg[i-1];
      pipe_sop_reg[i] <= pipe_sop_reg[i-1];
      pipe_eop_reg[i] <= pipe_eop_reg[i-1];
    end
  end

  assign ret_word = pipe_odd_reg[TOP] ? odd_q : even_q;
  assign push     = pipe_valid_reg[TOP];

`ifdef READ_CONTROL_CHECKSUM_EN
  logic [READ_LATENCY-1:0] pipe_chk_reg;
  logic [15:0]             sum_reg;

  assign chk_issue = (k_reg == KW'(PACKAGE_LENGTH));
  assign push_data = pipe_chk_reg[TOP] ? sum_reg : ret_word;

  always_ff @(posedge clk) begin
    pipe_chk_reg[0] <= chk_issue;
    for (int i = 1; i < READ_LATENCY; i++) pipe_chk_reg[i] <= pipe_chk_reg[i-1];
    if (clear) sum_reg <= '0;
    else if (push && !pipe_chk_reg[TOP])
      sum_reg <= (pipe_sop_reg[TOP] ? 16'd0 : sum_reg) + ret_word;
  end
`else
  assign chk_issue = 1'b0;
  assign push_data = ret_word;
`endif

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_reg] <= {pipe_sop_reg[TOP], pipe_eop_reg[TOP], push_data};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + FW'(1);
      if (pop)  rptr_reg <= rptr_reg + FW'(1);
      count_reg <= count_reg + (FW+1)'(push) - (FW+1)'(pop);
    end
  end

  assign head        = fifo_mem[rptr_reg];
  assign out_valid   = (count_reg != '0);
  assign out_data    = out_valid ? head[15:0] : 16'd0;
  assign out_sop     = out_valid && head[17];
  assign out_eop     = out_valid && head[16];
  assign busy        = (state_reg != IDLE);
  assign pkg_pending = pending_reg;
  assign overflow    = overflow_reg;
endmodule

// File: tb/tb_read_control.sv
// Randomized bench for read_control: memory model, expected-word queue and stream monitor.
`timescale 1ns/1ps
module tb_read_control;
  localparam int PL   = 1036;
  localparam int MD   = 24576;
  localparam int HALF = PL / 2;
  localparam int MAXP = MD / HALF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        live_rising = 1'b0;
  logic        wr_pkg_done = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] even_rdaddr, odd_rdaddr;
  logic [15:0] even_q, odd_q, out_data;
  logic        out_valid, out_sop, out_eop, busy, overflow;
  logic [5:0]  pkg_pending;

  read_control dut (
    .clk(clk), .reset(reset), .live_rising(live_rising), .wr_pkg_done(wr_pkg_done),
    .even_rdaddr(even_rdaddr), .even_q(even_q), .odd_rdaddr(odd_rdaddr), .odd_q(odd_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy),
    .pkg_pending(pkg_pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Two-cycle registered memories
  logic [15:0] even_mem [MD];
  logic [15:0] odd_mem  [MD];
  logic [15:0] even_s1, odd_s1;
  always @(posedge clk) begin
    even_s1 <= even_mem[even_rdaddr];
    odd_s1  <= odd_mem[odd_rdaddr];
    even_q  <= even_s1;
    odd_q   <= odd_s1;
  end

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;
  int model_base = 0;
  logic [15:0] model_sum;
  logic [17:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected words of the next package: word k from even (k even) or odd memory at base + k/2.
  task automatic add_pkg();
    int a;
    logic [15:0] w;
    model_sum = '0;
    for (int k = 0; k < PL; k++) begin
      a = (model_base + k / 2) % MD;
      w = (k % 2 == 0) ? even_mem[a] : odd_mem[a];
      model_sum = model_sum + w;
`ifdef READ_CONTROL_CHECKSUM_EN
      exp_q.push_back({k == 0, 1'b0, w});
`else
      exp_q.push_back({k == 0, k == PL - 1, w});
`endif
    end
`ifdef READ_CONTROL_CHECKSUM_EN
    exp_q.push_back({1'b0, 1'b1, model_sum});
`endif
    model_base = (model_base + HALF) % MD;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic pulse_done();
    wr_pkg_done = 1'b1;
    tick();
    wr_pkg_done = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || pkg_pending != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 0);
    check("idle_after_drain", 32'(busy), 0);
  endtask

  // Stream monitor: sampled on the falling edge, transfers complete on the next rising edge.
  logic [17:0] e, prev_word;
  logic        prev_stall = 1'b0;
  logic        busy_chk = 1'b0;
  logic        steady = 1'b0;
  int          pkg_words = 0;
  int          pkgs_done = 0;
  logic [15:0] last_eop_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy_chk) begin
        check("busy_after_eop", 32'(busy), 0);
        busy_chk = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_word", 32'({out_sop, out_eop, out_data}), 32'(prev_word));
      end
      if (steady && pkg_words > 0) check("no_gap", 32'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(out_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("word", 32'({out_sop, out_eop, out_data}), 32'(e));
          if (out_sop) begin
            pkg_words = 0;
            steady = (ready_mode == 1);
          end
          pkg_words++;
          if (out_eop) begin
            $display("pkg %0d streamed: words=%0d last=%h t=%0t", pkgs_done, pkg_words, out_data, $time);
            pkgs_done++;
            busy_chk = 1'b1;
            steady = 1'b0;
            last_eop_data = out_data;
            pkg_words = 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sop, out_eop, out_data};
      if (live_rising) begin
        exp_q.delete();
        prev_stall = 1'b0;
        steady = 1'b0;
        pkg_words = 0;
      end
    end
  end

  initial begin
    int n, base_before, model_pend;
    logic model_ovf;
    for (int i = 0; i < MD; i++) begin
      even_mem[i] = 16'(2 * i);
      odd_mem[i]  = 16'(2 * i + 1);
    end
    ready_mode = 1;
    tick(); tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_sop", 32'(out_sop), 0);
    check("rst_eop", 32'(out_eop), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pkg_pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_even_addr", 32'(even_rdaddr), 0);
    check("rst_odd_addr", 32'(odd_rdaddr), 0);
    reset = 1'b0;
    tick();

    // Idle-start latency and first package (words 0..1035)
    add_pkg();
    pulse_done();
    check("pend_c1", 32'(pkg_pending), 1);
    check("busy_c1", 32'(busy), 0);
    tick();
    check("pend_c2", 32'(pkg_pending), 0);
    check("busy_c2", 32'(busy), 1);
    check("addr_k0_even", 32'(even_rdaddr), 0);
    check("valid_c2", 32'(out_valid), 0);
    tick();
    check("addr_k1_odd", 32'(odd_rdaddr), 0);
    check("valid_c3", 32'(out_valid), 0);
    tick();
    check("addr_k2_even", 32'(even_rdaddr), 1);
    check("valid_c4", 32'(out_valid), 0);
    tick();
    check("valid_c5", 32'(out_valid), 1);
    check("sop_c5", 32'(out_sop), 1);
    check("data_c5", 32'(out_data), 0);
    wait_drain(3000);

    for (int i = 0; i < MD; i++) begin
      even_mem[i] = 16'($urandom);
      odd_mem[i]  = 16'($urandom);
    end

    // Three back-to-back packages with a randomly stalling sink
    ready_mode = 2;
    add_pkg(); add_pkg(); add_pkg();
    wr_pkg_done = 1'b1;
    tick(); tick(); tick();
    wr_pkg_done = 1'b0;
    wait_drain(14000);

    // Full-rate packages through the address wrap (package 47 spans 24575 -> 0)
    ready_mode = 1;
    for (int p = 4; p < 49; p++) begin
      base_before = model_base;
      add_pkg();
      pulse_done();
      tick();
      check("pkg_base", 32'(even_rdaddr), 32'(base_before));
      wait_drain(2000);
    end

    // Pending saturation and overflow with a blocked sink
    ready_mode = 0;
    tick();
    model_pend = 0;
    model_ovf = 1'b0;
    for (int i = 1; i <= MAXP + 2; i++) begin
      if (model_pend == MAXP) model_ovf = 1'b1;
      else model_pend++;
      pulse_done();
      check("sat_pending", 32'(pkg_pending), 32'(model_pend));
      check("sat_overflow", 32'(overflow), 32'(model_ovf));
      tick();
      if (i == 1) model_pend--;
    end
    live_rising = 1'b1;
    tick();
    live_rising = 1'b0;
    check("live_overflow", 32'(overflow), 0);
    check("live_pending", 32'(pkg_pending), 0);
    check("live_valid", 32'(out_valid), 0);
    check("live_busy", 32'(busy), 0);
    model_base = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("live_quiet", 32'(out_valid), 0);
    end

    // Soft restart in the middle of a package
    ready_mode = 1;
    tick();
    add_pkg();
    pulse_done();
    n = 0;
    while (pkg_words < 300 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_word300", 32'(pkg_words >= 300), 1);
    live_rising = 1'b1;
    tick();
    live_rising = 1'b0;
    check("abort_valid", 32'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_quiet", 32'({out_valid, out_eop}), 0);
    end
    model_base = 0;
    add_pkg();
    pulse_done();
    tick();
    check("restart_base", 32'(even_rdaddr), 0);
    wait_drain(2000);

`ifdef READ_CONTROL_CHECKSUM_EN
    for (int i = 0; i < HALF; i++) begin
      even_mem[(model_base + i) % MD] = 16'hFFFF;
      odd_mem[(model_base + i) % MD]  = 16'hFFFF;
    end
    add_pkg();
    pulse_done();
    wait_drain(2000);
    check("checksum_ffff", 32'(last_eop_data), 32'h0000FBF4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
